jpeg_huffman_symbol_decoder: RTL and testbench

Canonical JPEG Huffman decoder: the consuming side of the code/length tables produced from a DHT segment. It accepts a DHT table as BITS counts plus HUFFVAL symbols and builds MINCODE/MAXCODE/VALPTR internally in a fixed 16-cycle build phase. It then decodes a serial bitstream, one bit per cycle, into 8-bit symbols with their code lengths. It sits between the entropy bit-unstuffer and the run-length/coefficient stage.

---
 rtl/jpeg_huffman_symbol_decoder.sv | 186 ++++++++++++++++++
 tb/tb_jpeg_huffman_symbol_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_huffman_symbol_decoder.sv
// Canonical JPEG Huffman decoder: builds MINCODE/MAXCODE/VALPTR from BITS in 16 cycles,
// then turns a serial MSB-first bitstream into 8-bit symbols with their code lengths.
module jpeg_huffman_symbol_decoder #(
  parameter  int VAL_DEPTH = 256,
  parameter  int MAX_LEN   = 16,
  localparam int VAW       = $clog2(VAL_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cnt_wr_en,
  input  logic [3:0]     cnt_wr_addr,
  input  logic [7:0]     cnt_wr_data,
  input  logic           val_wr_en,
  input  logic [VAW-1:0] val_wr_addr,
  input  logic [7:0]     val_wr_data,
  input  logic           tbl_load,
  output logic           tbl_ready,
  input  logic           flush,
  input  logic           bit_valid,
  input  logic           bit_in,
  output logic           bit_ready,
  output logic           sym_valid,
  output logic [7:0]     sym_data,
  output logic [4:0]     sym_len,
  input  logic           sym_ready,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_BUILD, S_DECODE, S_OUT, S_ERR} state_t;

  state_t state, state_d;

  logic [7:0]         cnt_mem [MAX_LEN];
  logic [7:0]         val_mem [VAL_DEPTH];
  logic [16:0]        mincode [MAX_LEN];
  logic [16:0]        maxcode [MAX_LEN];
  logic [8:0]         valptr  [MAX_LEN];
  logic [MAX_LEN-1:0] empty;

  logic [3:0]  k;
  logic [16:0] code;
  logic [8:0]  idx;
  logic [14:0] c;
  logic [4:0]  len;

  logic           tbl_wr, load_go, bit_acc;
  logic [7:0]     cnt_k;
  logic [17:0]    code_sum, code_lim;
  logic [9:0]     idx_sum;
  logic           build_err;
  logic [15:0]    c_next;
  logic [3:0]     lidx;
  logic           hit, last;
  logic [VAW-1:0] vaddr;
  logic [7:0]     sym_val;

  assign tbl_wr  = (cnt_wr_en | val_wr_en) & (state != S_BUILD);
  assign load_go = tbl_load & (state != S_BUILD);
  assign bit_acc = bit_valid & (state == S_DECODE);

  // One BUILD step: the running code must stay within 2^(k+1) codes of length k+1.
  assign cnt_k     = cnt_mem[k];
  assign code_sum  = {1'b0, code} + 18'(cnt_k);
  assign code_lim  = 18'd2 << k;
  assign idx_sum   = {1'b0, idx} + 10'(cnt_k);
  assign build_err = (code_sum > code_lim) || (idx_sum > 10'(VAL_DEPTH));

  // c' is never below mincode when the shorter prefixes did not match, so only maxcode is compared.
  assign c_next  = {c, bit_in};
  assign lidx    = len[3:0];
  assign last    = (len == 5'd15);
  assign hit     = !empty[lidx] && ({1'b0, c_next} <= maxcode[lidx]);
  assign vaddr   = VAW'(valptr[lidx]) + VAW'({1'b0, c_next} - mincode[lidx]);
  assign sym_val = val_mem[vaddr];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    state_d   = state;
    bit_ready = 1'b0;
    unique case (state)
      S_IDLE:   ;
      S_BUILD: begin
        if (build_err)      state_d = S_ERR;
        else if (k == 4'd15) state_d = S_DECODE;
      end
      S_DECODE: begin
        bit_ready = 1'b1;
        if (bit_acc && !flush) begin
          if (hit)       state_d = S_OUT;
          else if (last) state_d = S_ERR;
        end
      end
      S_OUT:    if (sym_ready || flush) state_d = S_DECODE;
      S_ERR:    ;
      default:  state_d = S_IDLE;
    endcase
    if (load_go)     state_d = S_BUILD;
    else if (tbl_wr) state_d = S_IDLE;
  end

  // NOTE: table storage carries no reset; contents survive rst_n and are only replaced by writes.
  always_ff @(posedge clk) begin
    if (cnt_wr_en && state != S_BUILD) cnt_mem[cnt_wr_addr] <= cnt_wr_data;
    if (val_wr_en && state != S_BUILD) val_mem[val_wr_addr] <= val_wr_data;
    if (state == S_BUILD) begin
      mincode[k] <= code;
      maxcode[k] <= code + 17'(cnt_k) - 17'd1;
      valptr[k]  <= idx;
      empty[k]   <= (cnt_k == 8'd0);
    end
  end

  // Later statements override earlier ones: load beats table write beats flush beats the state action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      tbl_ready <= 1'b0;
      sym_valid <= 1'b0;
      sym_data  <= '0;
      sym_len   <= '0;
      err       <= 1'b0;
      k         <= '0;
      code      <= '0;
      idx       <= '0;
      c         <= '0;
      len       <= '0;
    end else begin
      unique case (state)
        S_BUILD: begin
          k    <= k + 4'd1;
          code <= {code_sum[15:0], 1'b0};
          idx  <= idx_sum[8:0];
          if (build_err)       err       <= 1'b1;
          else if (k == 4'd15) tbl_ready <= 1'b1;
        end
        S_DECODE: begin
          if (bit_acc && !flush) begin
            if (hit) begin
              sym_data  <= sym_val;
              sym_len   <= len + 5'd1;
              sym_valid <= 1'b1;
              c         <= '0;
              len       <= '0;
            end else if (last) begin
              err <= 1'b1;
              c   <= '0;
              len <= '0;
            end else begin
              c   <= c_next[14:0];
              len <= len + 5'd1;
            end
          end
        end
        S_OUT:   if (sym_ready) sym_valid <= 1'b0;
        default: ;
      endcase
      if (flush) begin
        c         <= '0;
        len       <= '0;
        sym_valid <= 1'b0;
      end
      if (tbl_wr) begin
        tbl_ready <= 1'b0;
        sym_valid <= 1'b0;
        c         <= '0;
        len       <= '0;
      end
      if (load_go) begin
        err       <= 1'b0;
        sym_valid <= 1'b0;
        tbl_ready <= 1'b0;
        k         <= '0;
        code      <= '0;
        idx       <= '0;
        c         <= '0;
        len       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_huffman_symbol_decoder.sv
// Directed and randomized bench for jpeg_huffman_symbol_decoder; expected symbols come from
// a canonical code generator that walks BITS/HUFFVAL the way a DHT parser does.
module tb_jpeg_huffman_symbol_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_wr_en = 1'b0;
  logic [3:0] cnt_wr_addr = '0;
  logic [7:0] cnt_wr_data = '0;
  logic       val_wr_en = 1'b0;
  logic [7:0] val_wr_addr = '0;
  logic [7:0] val_wr_data = '0;
  logic       tbl_load = 1'b0;
  logic       tbl_ready;
  logic       flush = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_ready;
  logic       sym_valid;
  logic [7:0] sym_data;
  logic [4:0] sym_len;
  logic       sym_ready = 1'b1;
  logic       err;

  jpeg_huffman_symbol_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .cnt_wr_en(cnt_wr_en), .cnt_wr_addr(cnt_wr_addr), .cnt_wr_data(cnt_wr_data),
    .val_wr_en(val_wr_en), .val_wr_addr(val_wr_addr), .val_wr_data(val_wr_data),
    .tbl_load(tbl_load), .tbl_ready(tbl_ready), .flush(flush),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_len(sym_len),
    .sym_ready(sym_ready), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_bits [16];
  int m_vals [256];
  int m_nvals = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Canonical code assignment: codes of each length count up, then shift left for the next length.
  task automatic model_code(input int n, output logic [15:0] code, output int len,
                            output logic [7:0] sym);
    int cur = 0;
    int pos = 0;
    code = '0;
    len  = 0;
    sym  = '0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < m_bits[l-1]; j++) begin
        if (pos == n) begin
          code = 16'(cur);
          len  = l;
          sym  = 8'(m_vals[pos]);
        end
        cur++;
        pos++;
      end
      cur = cur << 1;
    end
  endtask

  task automatic write_tables();
    m_nvals = 0;
    for (int i = 0; i < 16; i++) begin
      m_nvals += m_bits[i];
      cnt_wr_en = 1'b1; cnt_wr_addr = 4'(i); cnt_wr_data = 8'(m_bits[i]);
      tick();
    end
    cnt_wr_en = 1'b0;
    for (int i = 0; i < m_nvals; i++) begin
      val_wr_en = 1'b1; val_wr_addr = 8'(i); val_wr_data = 8'(m_vals[i]);
      tick();
    end
    val_wr_en = 1'b0;
    check("tbl_ready_after_write", tbl_ready, 0);
  endtask

  task automatic start_build();
    tbl_load = 1'b1;
    tick();
    tbl_load = 1'b0;
    check("err_after_load", err, 0);
    repeat (15) tick();
    check("tbl_ready_at_15", tbl_ready, 0);
    tick();
    check("tbl_ready_at_16", tbl_ready, 1);
    check("err_after_build", err, 0);
  endtask

  task automatic decode_code(input logic [15:0] code, input int len, input logic [7:0] exp_sym,
                             input int hold);
    for (int i = len - 1; i >= 0; i--) begin
      check("bit_ready_in_decode", bit_ready, 1);
      bit_valid = 1'b1;
      bit_in    = code[i];
      tick();
      if (i > 0) check("sym_valid_early", sym_valid, 0);
    end
    bit_valid = 1'b0;
    check("sym_valid", sym_valid, 1);
    check("sym_data", sym_data, exp_sym);
    check("sym_len", sym_len, len);
    if (hold > 0) begin
      sym_ready = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      repeat (hold) begin
        tick();
        check("hold_sym_valid", sym_valid, 1);
        check("hold_sym_data", sym_data, exp_sym);
        check("hold_bit_ready", bit_ready, 0);
      end
      bit_valid = 1'b0;
      sym_ready = 1'b1;
    end
    tick();
    check("sym_valid_drop", sym_valid, 0);
    check("bit_ready_after_drop", bit_ready, 1);
  endtask

  task automatic decode_index(input int n, input int hold);
    logic [15:0] code;
    int          len;
    logic [7:0]  sym;
    model_code(n, code, len, sym);
    decode_code(code, len, sym, hold);
  endtask

  task automatic send_raw(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic set_dc_lum();
    m_bits = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 256; i++) m_vals[i] = i % 256;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_tbl_ready", tbl_ready, 0);
    check("rst_bit_ready", bit_ready, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_err", err, 0);
    check("rst_sym_data", sym_data, 0);
    check("rst_sym_len", sym_len, 0);
    rst_n = 1'b1;
    tick();

    // Standard DC luminance table
    set_dc_lum();
    write_tables();
    start_build();

    // Directed stream 00, 010, 1110, 111111110
    decode_code(16'b00, 2, 8'd0, 0);
    decode_code(16'b010, 3, 8'd1, 0);
    decode_code(16'b1110, 4, 8'd6, 0);
    decode_code(16'b111111110, 9, 8'd11, 0);

    // Backpressure: symbol 5 held for 5 cycles, then the next symbol decodes cleanly
    decode_code(16'b110, 3, 8'd5, 5);
    decode_code(16'b00, 2, 8'd0, 0);

    // Randomized symbol stream with random backpressure
    for (int n = 0; n < 40; n++)
      decode_index($urandom_range(0, m_nvals - 1), $urandom_range(0, 2));

    // Sixteen 1 bits never match
    for (int i = 1; i <= 16; i++) begin
      check("ones_bit_ready", bit_ready, 1);
      send_raw(1'b1);
      if (i == 15) check("ones_err_before_16", err, 0);
    end
    check("ones_err", err, 1);
    check("ones_bit_ready_err", bit_ready, 0);
    check("ones_sym_valid", sym_valid, 0);
    check("ones_tbl_ready_err", tbl_ready, 1);
    repeat (3) tick();
    check("ones_err_sticky", err, 1);
    start_build();
    decode_index(3, 0);

    // Flush discards the partial code 11
    send_raw(1'b1);
    send_raw(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    decode_code(16'b00, 2, 8'd0, 0);

    // Flush discards an undelivered symbol
    send_raw(1'b0);
    send_raw(1'b0);
    check("flush_pending_valid", sym_valid, 1);
    sym_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    sym_ready = 1'b1;
    check("flush_sym_valid", sym_valid, 0);
    check("flush_bit_ready", bit_ready, 1);
    decode_index(6, 0);

    // Table with only 1-bit codes
    m_bits = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_vals[0] = 8'hA5;
    m_vals[1] = 8'h5A;
    write_tables();
    start_build();
    decode_code(16'b1, 1, 8'h5A, 0);
    decode_code(16'b0, 1, 8'hA5, 1);
    for (int n = 0; n < 10; n++) decode_index($urandom_range(0, 1), $urandom_range(0, 1));

    // Overfull table fails at k=0
    m_bits = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    write_tables();
    tbl_load = 1'b1;
    tick();
    tbl_load = 1'b0;
    check("overfull_err_k0_pending", err, 0);
    tick();
    check("overfull_err", err, 1);
    check("overfull_tbl_ready", tbl_ready, 0);
    check("overfull_bit_ready", bit_ready, 0);
    repeat (16) tick();
    check("overfull_tbl_ready_late", tbl_ready, 0);

    // Reset in the middle of a build; tables survive reset
    set_dc_lum();
    write_tables();
    tbl_load = 1'b1;
    tick();
    tbl_load = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_tbl_ready", tbl_ready, 0);
    check("midrst_bit_ready", bit_ready, 0);
    check("midrst_sym_valid", sym_valid, 0);
    check("midrst_err", err, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("midrst_idle_tbl_ready", tbl_ready, 0);
    check("midrst_idle_bit_ready", bit_ready, 0);
    start_build();
    decode_index(11, 0);
    for (int n = 0; n < 10; n++) decode_index($urandom_range(0, m_nvals - 1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
